pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program sequencer: owns the program counter, drives the program-memory address,
//  decodes branch/call/return opcodes from the fetched word, and evaluates CU flags.
//  Sits between pgm memory and CU; adds a stall handshake and a hardware return stack.
// PARAMETERS
//  AW       5   program-counter / address width (memory depth 2**AW)
//  IW       15  instruction width; opcode = instr_i[IW-1:IW-4]
//  TGT_LSB  3   LSB of branch target field; target = instr_i[TGT_LSB+AW-1:TGT_LSB]
//  FW       2   CU flag width
//  SD       4   return-stack depth (entries), >=1
// PORTS
//  clk          in   1    system clock, all state on posedge
//  rst          in   1    synchronous, active-high reset
//  instr_i      in   IW   word at address pc_o (from program memory)
//  instr_vld_i  in   1    instr_i is valid this cycle
//  stall_i      in   1    CU busy: hold PC and stack
//  flag_i       in   FW   CU flags; bit1 = cond A, bit0 = cond B
//  pc_o         out  AW   current fetch address
//  taken_o      out  1    1-cycle pulse: last update loaded a non-sequential PC
//  stk_depth_o  out  $clog2(SD+1)  live return-stack occupancy
//  stk_err_o    out  1    sticky: overflow or underflow seen since reset
// BEHAVIOUR
//  Reset (sync, wins over everything): pc_o=0, taken_o=0, stk_depth_o=0, stk_err_o=0.
//  Advance = instr_vld_i & ~stall_i. No advance: all state held, taken_o=0.
//  On advance, next PC by opcode (latency 1 clk, registered):
//   4'b0000 BRA  flag_i[1] ? tgt : pc+1          4'b1100 BRB  flag_i[0] ? tgt : pc+1
//   4'b1101 JMP  tgt                              4'b1110 CALL push pc+1, pc<=tgt
//   4'b1111 RET  pc<=pop                          other        pc+1
//  pc+1 wraps modulo 2**AW (all-ones -> 0); return address of CALL at top wraps likewise.
//  taken_o=1 the cycle after any advance whose next PC came from tgt or pop.
//  CALL with stack full: no push, pc+1, stk_err_o<=1. RET with stack empty: pc+1, stk_err_o<=1.
//  Flags sampled in the same cycle as the branch word; no flag forwarding/registering inside.
//  Reset mid-CALL/RET: stack contents discarded, depth 0.
// CONFIGURATION
//  SEQ_CALL_STACK_EN defined: CALL/RET as above, stack instantiated.
//  Not defined: CALL/RET decode as "other" (pc+1), no stack storage, stk_depth_o=0, stk_err_o=0.
// STRUCTURE
//  Package seq_pkg: opcode localparams (OP_BRA, OP_BRB, OP_JMP, OP_CALL, OP_RET), opcode width 4.
//  Sub-module seq_ret_stack (SD x AW LIFO: push/pop/full/empty/depth), under SEQ_CALL_STACK_EN.
//  Top: next-PC mux, PC register, taken/err registers.
// TESTING (defaults)
//  rst=1 2 clks, then vld=1 with NOP words -> pc_o 0,1,2..31,0 (wrap), taken_o=0 throughout.
//  BRA tgt=5'd20 at pc=3, flag_i=2'b10 -> pc_o=20 next clk, taken_o=1 one clk; flag=2'b00 -> pc_o=4.
//  stall_i=1 for 3 clks with JMP tgt=9 present -> pc_o unchanged; stall drop -> pc_o=9 next clk.
//  CALL tgt=10 at pc=2, RET at 10 -> pc_o 2,10,3; stk_depth_o 0,1,0.
//  5 nested CALLs (SD=4) -> 5th gives pc+1, stk_err_o=1 sticky; RET on empty -> pc+1, err stays 1.
//  Macro off: CALL tgt=10 at pc=2 -> pc_o=3, taken_o=0, stk_depth_o=0; rst during stall -> pc_o=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcode encodings for the program sequencer.
// Opcode occupies the top OPC_W bits of each instruction word.
package seq_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_BRA  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_BRB  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1101;
  localparam logic [OPC_W-1:0] OP_CALL = 4'b1110;
  localparam logic [OPC_W-1:0] OP_RET  = 4'b1111;

endpackage

// File: rtl/seq_ret_stack.sv
// Hardware return stack: SD-entry LIFO of AW-bit return addresses.
// Push while full and pop while empty are ignored; the caller flags those errors.
module seq_ret_stack #(
  parameter int AW = 5,
  parameter int SD = 4,
  parameter int DW = $clog2(SD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  localparam int AI = (SD > 1) ? $clog2(SD) : 1;

  logic [AW-1:0] mem [SD];
  logic [DW-1:0] cnt;
  logic [DW-1:0] top_idx;
  logic          unused_idx;

  assign full    = (cnt == DW'(SD));
  assign empty   = (cnt == '0);
  assign depth   = cnt;
  assign top_idx = cnt - 1'b1;
  assign top     = mem[top_idx[AI-1:0]];
  assign unused_idx = ^top_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[cnt[AI-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC register, branch/jump decode, optional call/return stack.
// Define SEQ_CALL_STACK_EN to enable CALL/RET and the return stack.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int AW      = 5,
  parameter int IW      = 15,
  parameter int TGT_LSB = 3,
  parameter int FW      = 2,
  parameter int SD      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IW-1:0]            instr_i,
  input  logic                     instr_vld_i,
  input  logic                     stall_i,
  input  logic [FW-1:0]            flag_i,
  output logic [AW-1:0]            pc_o,
  output logic                     taken_o,
  output logic [$clog2(SD+1)-1:0]  stk_depth_o,
  output logic                     stk_err_o
);

  logic             adv;
  logic [OPC_W-1:0] opcode;
  logic [AW-1:0]    tgt;
  logic [AW-1:0]    pc_inc;
  logic [AW-1:0]    pc_nxt;
  logic             jump;
  logic             unused_bits;

  assign adv         = instr_vld_i & ~stall_i;
  assign opcode      = instr_i[IW-1 -: OPC_W];
  assign tgt         = instr_i[TGT_LSB +: AW];
  assign pc_inc      = pc_o + 1'b1;
  assign unused_bits = ^{instr_i, flag_i};

`ifdef SEQ_CALL_STACK_EN
  logic          push;
  logic          pop;
  logic          err_set;
  logic [AW-1:0] stk_top;
  logic          stk_full;
  logic          stk_empty;

  // Flags are consumed combinationally in the same cycle as the branch word.
  always_comb begin
    pc_nxt  = pc_inc;
    jump    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (opcode)
      OP_BRA:  if (flag_i[1]) begin pc_nxt = tgt; jump = 1'b1; end
      OP_BRB:  if (flag_i[0]) begin pc_nxt = tgt; jump = 1'b1; end
      OP_JMP:  begin pc_nxt = tgt; jump = 1'b1; end
      OP_CALL: begin
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push   = adv;
          pc_nxt = tgt;
          jump   = 1'b1;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          err_set = 1'b1;
        end else begin
          pop    = adv;
          pc_nxt = stk_top;
          jump   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stk_err_o <= 1'b0;
    end else if (adv && err_set) begin
      stk_err_o <= 1'b1;
    end
  end

  seq_ret_stack #(
    .AW (AW),
    .SD (SD)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (stk_depth_o)
  );
`else
  always_comb begin
    pc_nxt = pc_inc;
    jump   = 1'b0;
    case (opcode)
      OP_BRA:  if (flag_i[1]) begin pc_nxt = tgt; jump = 1'b1; end
      OP_BRB:  if (flag_i[0]) begin pc_nxt = tgt; jump = 1'b1; end
      OP_JMP:  begin pc_nxt = tgt; jump = 1'b1; end
      default: ;
    endcase
  end

  assign stk_depth_o = '0;
  assign stk_err_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o    <= '0;
      taken_o <= 1'b0;
    end else begin
      taken_o <= adv & jump;
      if (adv) begin
        pc_o <= pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random bench for pc_sequencer with a behavioural model and scoreboard.
// Expectations follow SEQ_CALL_STACK_EN as defined for the build.
module tb_pc_sequencer;

  localparam int AW = 5;
  localparam int IW = 15;
  localparam int TGT_LSB = 3;
  localparam int FW = 2;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);
`ifdef SEQ_CALL_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  localparam logic [3:0] NOP  = 4'b0001;
  localparam logic [3:0] BRA  = 4'b0000;
  localparam logic [3:0] BRB  = 4'b1100;
  localparam logic [3:0] JMP  = 4'b1101;
  localparam logic [3:0] CALL = 4'b1110;
  localparam logic [3:0] RET  = 4'b1111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] instr = '0;
  logic          vld = 1'b0;
  logic          stall = 1'b0;
  logic [FW-1:0] flag = '0;
  logic [AW-1:0] pc;
  logic          taken;
  logic [DW-1:0] depth;
  logic          err;

  always #5 clk = ~clk;

  pc_sequencer #(
    .AW(AW), .IW(IW), .TGT_LSB(TGT_LSB), .FW(FW), .SD(SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_i     (instr),
    .instr_vld_i (vld),
    .stall_i     (stall),
    .flag_i      (flag),
    .pc_o        (pc),
    .taken_o     (taken),
    .stk_depth_o (depth),
    .stk_err_o   (err)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic          taken;
    logic [DW-1:0] depth;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_pc = 0;
  int   m_stk[$];
  bit   m_err = 1'b0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Spare instruction bits are randomised to confirm the decoder ignores them.
  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [AW-1:0] t);
    logic [2:0] s_hi, s_lo;
    s_hi = 3'($urandom);
    s_lo = 3'($urandom);
    return {op, s_hi, t, s_lo};
  endfunction

  task automatic step(input bit r, input bit v, input bit s, input logic [3:0] op,
                      input logic [AW-1:0] t, input logic [FW-1:0] f);
    exp_t e;
    int   inc;
    bit   tk;
    @(negedge clk);
    rst = r; vld = v; stall = s; instr = mk(op, t); flag = f;
    inc = (m_pc + 1) % (1 << AW);
    tk  = 1'b0;
    if (r) begin
      m_pc = 0; m_stk.delete(); m_err = 1'b0;
    end else if (v && !s) begin
      case (op)
        BRA: if (f[1]) begin m_pc = int'(t); tk = 1'b1; end else m_pc = inc;
        BRB: if (f[0]) begin m_pc = int'(t); tk = 1'b1; end else m_pc = inc;
        JMP: begin m_pc = int'(t); tk = 1'b1; end
        CALL: begin
          if (STK_EN && m_stk.size() < SD) begin
            m_stk.push_back(inc); m_pc = int'(t); tk = 1'b1;
          end else begin
            if (STK_EN) m_err = 1'b1;
            m_pc = inc;
          end
        end
        RET: begin
          if (STK_EN && m_stk.size() > 0) begin
            m_pc = m_stk.pop_back(); tk = 1'b1;
          end else begin
            if (STK_EN) m_err = 1'b1;
            m_pc = inc;
          end
        end
        default: m_pc = inc;
      endcase
    end
    e.pc = AW'(m_pc); e.taken = tk; e.depth = DW'(m_stk.size()); e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc",    8'(pc),    8'(e.pc));
    check("taken", 8'(taken), 8'(e.taken));
    check("depth", 8'(depth), 8'(e.depth));
    check("err",   8'(err),   8'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ops [7];
    ops = '{BRA, BRB, JMP, CALL, RET, NOP, 4'b0101};

    // Reset held two clocks
    step(1, 0, 0, NOP, 0, 0);
    step(1, 1, 0, JMP, 5'd7, 0);
    check("rst_pc_lit", 8'(pc), 8'd0);

    // Sequential run with wrap 31 -> 0
    for (int i = 0; i < 33; i++) step(0, 1, 0, NOP, 5'(i), 2'b11);
    check("wrap_pc_lit", 8'(pc), 8'd1);

    // BRA taken / not taken, BRB
    step(1, 1, 0, NOP, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, NOP, 0, 0);
    step(0, 1, 0, BRA, 5'd20, 2'b10);
    check("bra_pc_lit", 8'(pc), 8'd20);
    check("bra_taken_lit", 8'(taken), 8'd1);
    step(0, 1, 0, NOP, 0, 0);
    step(1, 1, 0, NOP, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, NOP, 0, 0);
    step(0, 1, 0, BRA, 5'd20, 2'b00);
    check("bra_nt_pc_lit", 8'(pc), 8'd4);
    step(0, 1, 0, BRA, 5'd20, 2'b01);
    step(0, 1, 0, BRB, 5'd7, 2'b01);
    step(0, 1, 0, BRB, 5'd30, 2'b10);

    // Stall and invalid words hold state
    for (int i = 0; i < 3; i++) step(0, 1, 1, JMP, 5'd9, 0);
    step(0, 0, 0, JMP, 5'd9, 0);
    step(0, 1, 0, JMP, 5'd9, 0);
    check("jmp_pc_lit", 8'(pc), 8'd9);

    // CALL at pc=2, RET at callee
    step(1, 1, 0, NOP, 0, 0);
    step(0, 1, 0, NOP, 0, 0);
    step(0, 1, 0, NOP, 0, 0);
    step(0, 1, 0, CALL, 5'd10, 0);
    check("call_pc_lit", 8'(pc), STK_EN ? 8'd10 : 8'd3);
    step(0, 1, 0, RET, 5'd0, 0);
    check("ret_pc_lit", 8'(pc), STK_EN ? 8'd3 : 8'd4);

    // Nested CALL overflow, then drain and underflow
    step(1, 1, 0, NOP, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, CALL, 5'(10 + 2 * i), 0);
    check("ovf_err_lit", 8'(err), STK_EN ? 8'd1 : 8'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, RET, 0, 0);
    step(0, 1, 0, NOP, 0, 0);

    // CALL at top address wraps its return address to 0
    step(0, 1, 0, JMP, 5'd31, 0);
    step(0, 1, 0, CALL, 5'd5, 0);
    step(0, 1, 0, RET, 0, 0);

    // Reset during stall and mid-CALL
    step(0, 1, 0, CALL, 5'd12, 0);
    step(1, 1, 1, JMP, 5'd9, 0);
    step(0, 1, 0, CALL, 5'd14, 0);
    step(1, 1, 0, CALL, 5'd16, 0);
    check("rst_depth_lit", 8'(depth), 8'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 4) == 0), ops[$urandom_range(0, 6)],
           5'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
